// File: rtl/fsm_step_scheduler_pkg.sv
// Shared types for the step scheduler: scheduler FSM states and the Gray-coded
// step machine encoding with its successor function.
package fsm_step_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b11,
    S3 = 2'b10
  } step_state_e;

  function automatic step_state_e step_next(step_state_e s);
    case (s)
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      S3:      return S0;
      default: return S0;
    endcase
  endfunction

endpackage

// File: rtl/fsm_step_scheduler_if.sv
// Request/grant and step-machine observation bundle between requesters and the
// scheduler.
interface fsm_step_scheduler_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 4
) ();
  localparam int unsigned ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] req_steps;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  E;
  logic                  A;
  logic                  B;
  logic                  Q;
  logic                  done;
  logic [ID_W-1:0]       done_id;
  logic [CNT_W-1:0]      steps_left;

  modport master (
    output req, req_steps,
    input  gnt, busy, E, A, B, Q, done, done_id, steps_left
  );

  modport slave (
    input  req, req_steps,
    output gnt, busy, E, A, B, Q, done, done_id, steps_left
  );
endinterface

// File: rtl/fsm_step_scheduler_step_fsm.sv
// Enable-driven 4-state Gray stepper (00->01->11->10->00) with Moore flag Q
// asserted in state 10.
module step_fsm
  import fsm_step_scheduler_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic E,
  output logic A,
  output logic B,
  output logic Q
);

  step_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (E) state_d = step_next(state_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S0;
    else     state_q <= state_d;
  end

  assign {A, B} = state_q;
  assign Q      = (state_q == S3);

endmodule

// File: rtl/fsm_step_scheduler.sv
// Round-robin scheduler granting the shared step machine to one requester at a
// time and enabling it for exactly the requested number of cycles.
module fsm_step_scheduler
  import fsm_step_scheduler_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 4
) (
  input logic                CLK,
  input logic                RST,
  fsm_step_scheduler_if.slave bus
);

  localparam int unsigned ID_W = $clog2(NREQ);

  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             e_q, e_d;
  logic [ID_W-1:0]  sel;
  logic [CNT_W-1:0] sel_cnt;

  // First requester at or above the pointer, searching upward with wrap.
  function automatic logic [ID_W-1:0] rr_select(logic [NREQ-1:0] r, logic [ID_W-1:0] p);
    logic [ID_W-1:0] s;
    s = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(p) + i) % int'(NREQ);
      if (r[idx]) s = ID_W'(idx);
    end
    return s;
  endfunction

  assign sel     = rr_select(bus.req, ptr_q);
  assign sel_cnt = bus.req_steps[int'(sel)*int'(CNT_W) +: CNT_W];

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    steps_d = steps_q;
    gnt_d   = gnt_q;
    e_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          id_d    = sel;
          steps_d = sel_cnt;
          gnt_d   = NREQ'(1) << sel;
          if (sel_cnt != '0) begin
            state_d = RUN;
            e_d     = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        steps_d = steps_q - 1'b1;
        if (steps_q == CNT_W'(1)) state_d = DONE;
        else                      e_d     = 1'b1;
      end
      DONE: begin
        ptr_d   = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      steps_q <= '0;
      gnt_q   <= '0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      steps_q <= steps_d;
      gnt_q   <= gnt_d;
      e_q     <= e_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.E          = e_q;
  assign bus.done       = (state_q == DONE);
  assign bus.done_id    = id_q;
  assign bus.steps_left = steps_q;

  step_fsm u_step (
    .CLK (CLK),
    .RST (RST),
    .E   (e_q),
    .A   (bus.A),
    .B   (bus.B),
    .Q   (bus.Q)
  );

endmodule

// File: doc/fsm_step_scheduler.md
Name: fsm_step_scheduler

Overview:
Round-robin scheduler that shares one enable-driven 2-bit state machine (outputs A, B, Q) among NREQ requesters. Each requester asks for a number of enable steps. The scheduler grants one requester at a time, drives the machine's enable for exactly that many cycles, then reports the resulting state. It sits between requesting control logic and the step machine, which is instantiated inside this block.

Parameters:
NREQ, 4, number of requesters (2..8)
CNT_W, 4, width of each step-count request (max 2^CNT_W-1 steps)

Ports:
CLK  input  1  system clock, rising-edge
RST  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request level
req_steps  input  NREQ*CNT_W  step count per requester; slice i = [i*CNT_W +: CNT_W]
gnt  output  NREQ  one-hot grant; high in RUN and DONE
busy  output  1  high whenever state != IDLE
E  output  1  enable to step machine; registered, high exactly during RUN cycles
A  output  1  step machine state bit (MSB)
B  output  1  step machine state bit (LSB)
Q  output  1  step machine flag
done  output  1  one-cycle pulse at end of a grant
done_id  output  $clog2(NREQ)  index of completed requester; valid with done
steps_left  output  CNT_W  remaining steps of the current grant

Behaviour:
- Reset (async, RST=1): state=IDLE; gnt=0, busy=0, E=0, done=0, done_id=0, steps_left=0; step machine {A,B}=00, Q=0; round-robin pointer=0.
- Step machine: on each rising edge with E=1 it advances {A,B} through 00→01→11→10→00 (wraps). With E=0 it holds. Q=1 iff {A,B}==10 (Moore output).
- Step machine is NOT reset between grants. The state carries over from one requester to the next, because it is the shared resource.
- FSM states: IDLE, RUN, DONE.
- IDLE: if any req is high at the edge:
  - Select the first requester at index >= pointer, searching upward modulo NREQ.
  - Latch id and req_steps[id] into steps_left.
  - Go to RUN if the count != 0; go to DONE if the count == 0.
  - No req high: stay in IDLE.
- RUN: E=1. Each edge advances the step machine and decrements steps_left. At the edge where steps_left==1, go to DONE (steps_left becomes 0).
- DONE: done=1, done_id=id, E=0. Next edge: pointer=(id+1) mod NREQ, gnt cleared, go to IDLE.
- Latency: request sampled at edge 0 → RUN cycles 1..n → DONE in cycle n+1 → IDLE in cycle n+2. There is at least one IDLE cycle between consecutive grants. Exactly n enable pulses per grant.
- req and req_steps are sampled only in IDLE:
  - Dropping req mid-grant is ignored; the grant runs to completion.
  - Changing req_steps mid-grant has no effect.
- Simultaneous requests: resolved only by the round-robin pointer; there is no fixed priority.
- Zero-step request: granted for one cycle (DONE only), E never asserted, {A,B} unchanged.
- Reset mid-RUN: everything returns to reset values immediately; the partial grant is lost and no done pulse is produced.
- gnt is always one-hot or zero; it is never asserted in IDLE.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - step-machine encoding: S0=00, S1=01, S2=11, S3=10
- Sub-module step_fsm: ports CLK, RST, E, A, B, Q. It implements the 4-state Gray stepper with Q decode, and is instantiated once in the scheduler.
- The round-robin select is a combinational function inside the scheduler.

Test Plan:
1. From reset, req[0]=1, steps=2 → E high exactly 2 cycles; at done, A=1, B=1, Q=0, done_id=0; gnt=0001 during RUN and DONE.
2. req[1]=1, steps=4 starting from {A,B}=00 → sequence 01, 11, 10, 00. Q=1 for exactly one cycle (state 10). Final {A,B}=00; done one cycle after the 4th enable.
3. req[0] and req[2] raised in the same cycle, steps=1 each, pointer=0 → grant 0 completes first, then one IDLE cycle, then grant 2. done_id sequence is 0, 2.
4. req[3]=1, steps=0 → gnt=1000 and done=1 for one cycle, E never high, {A,B} unchanged, busy high one cycle.
5. All four requesters held high, steps=1 each → grant order 0, 1, 2, 3, 0. Each grant lasts 2 busy cycles plus 1 idle; no requester is skipped.
6. RST pulsed during the 3rd cycle of a 5-step RUN → immediately gnt=0, E=0, {A,B}=00, pointer=0, no done pulse. A subsequent request is serviced normally.
